// File: rtl/ui_control_bank.sv
// Mouse-driven bank of saturating setting registers, one per horizontal screen zone.
// Supports edge-triggered steps with auto-repeat, a coarse/fine modifier and a both-button restore to default.
`timescale 1ns/1ps
module ui_control_bank #(
  parameter int               NUM_CTRL      = 4,
  parameter int               VAL_W         = 12,
  parameter logic [VAL_W-1:0] VAL_INIT      = 12'd2048,
  parameter int               VAL_MIN       = 0,
  parameter int               VAL_MAX       = 4095,
  parameter int               FINE_STEP     = 1,
  parameter int               COARSE_STEP   = 16,
  parameter int               ZONE_WIDTH    = 256,
  parameter int               REPEAT_DELAY  = 25_000_000,
  parameter int               REPEAT_PERIOD = 5_000_000
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          left_mouse,
  input  logic                          right_mouse,
  input  logic                          middle_mouse,
  input  logic [11:0]                   xpos,
  input  logic [11:0]                   ypos,
  output logic [NUM_CTRL*VAL_W-1:0]     values,
  output logic                          change_strobe,
  output logic [$clog2(NUM_CTRL)-1:0]   change_idx,
  output logic [$clog2(NUM_CTRL):0]     active_idx
);

  localparam int IDX_W   = $clog2(NUM_CTRL);
  localparam int SUM_W   = VAL_W + 2;
  localparam int CNT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int CNT_W   = $clog2(CNT_MAX) + 1;

  localparam logic [11:0]             ZONE_W_L    = 12'(ZONE_WIDTH);
  localparam logic [11:0]             NUM_CTRL_L  = 12'(NUM_CTRL);
  localparam logic [11:0]             Y_LIMIT     = 12'd600;
  localparam logic signed [SUM_W-1:0] FINE_S      = SUM_W'(FINE_STEP);
  localparam logic signed [SUM_W-1:0] COARSE_S    = SUM_W'(COARSE_STEP);
  localparam logic signed [SUM_W-1:0] MIN_S       = SUM_W'(VAL_MIN);
  localparam logic signed [SUM_W-1:0] MAX_S       = SUM_W'(VAL_MAX);
  localparam logic [CNT_W-1:0]        DELAY_LAST  = CNT_W'(REPEAT_DELAY - 1);
  localparam logic [CNT_W-1:0]        PERIOD_LAST = CNT_W'(REPEAT_PERIOD - 1);

  typedef enum logic [1:0] {ST_IDLE, ST_DELAY, ST_REPEAT, ST_LOCK} state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [IDX_W-1:0]   lat_idx_q, lat_idx_d;
  logic               lat_up_q, lat_up_d;
  logic               prev_l, prev_r;
  logic [VAL_W-1:0]   val_q [NUM_CTRL];

  logic [11:0]             zone_raw;
  logic [IDX_W-1:0]        zone;
  logic                    zone_valid;
  logic                    rise_l, rise_r;
  logic [IDX_W-1:0]        tgt_idx;
  logic                    tgt_up;
  logic signed [SUM_W-1:0] old_s, mag_s, sum_s, clamp_s;
  logic [VAL_W-1:0]        step_val;
  logic                    held, opposite;
  logic                    wr_en, wr_chg;
  logic [IDX_W-1:0]        wr_idx;
  logic [VAL_W-1:0]        wr_val;

  assign zone_raw   = xpos / ZONE_W_L;
  assign zone       = zone_raw[IDX_W-1:0];
  assign zone_valid = (zone_raw < NUM_CTRL_L) && (ypos < Y_LIMIT);
  assign rise_l     = left_mouse  & ~prev_l;
  assign rise_r     = right_mouse & ~prev_r;

  // In IDLE the step targets the zone under the cursor; while repeating it targets the latched one.
  assign tgt_idx = (state_q == ST_IDLE) ? zone        : lat_idx_q;
  assign tgt_up  = (state_q == ST_IDLE) ? right_mouse : lat_up_q;

  always_comb begin
    old_s = $signed({2'b00, val_q[tgt_idx]});
    mag_s = middle_mouse ? COARSE_S : FINE_S;
    sum_s = tgt_up ? (old_s + mag_s) : (old_s - mag_s);
    if (sum_s < MIN_S)      clamp_s = MIN_S;
    else if (sum_s > MAX_S) clamp_s = MAX_S;
    else                    clamp_s = sum_s;
    step_val = clamp_s[VAL_W-1:0];
  end

  assign held     = lat_up_q ? right_mouse : left_mouse;
  assign opposite = lat_up_q ? left_mouse  : right_mouse;

  // NOTE: every output of this block gets a default first, so no path can infer a latch.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    lat_idx_d = lat_idx_q;
    lat_up_d  = lat_up_q;
    wr_en     = 1'b0;
    wr_idx    = tgt_idx;
    wr_val    = step_val;
    unique case (state_q)
      ST_IDLE: begin
        if (left_mouse && right_mouse && (rise_l || rise_r)) begin
          state_d = ST_LOCK;
          if (zone_valid) begin
            wr_en  = 1'b1;
            wr_idx = zone;
            wr_val = VAL_INIT;
          end
        end else if ((rise_l ^ rise_r) && zone_valid) begin
          wr_en     = 1'b1;
          lat_idx_d = zone;
          lat_up_d  = rise_r;
          cnt_d     = '0;
          state_d   = ST_DELAY;
        end
      end
      ST_DELAY, ST_REPEAT: begin
        if (opposite) begin
          state_d = ST_LOCK;
        end else if (!held || !zone_valid || (zone != lat_idx_q)) begin
          state_d = ST_IDLE;
        end else if (cnt_q == ((state_q == ST_DELAY) ? DELAY_LAST : PERIOD_LAST)) begin
          wr_en   = 1'b1;
          cnt_d   = '0;
          state_d = ST_REPEAT;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_LOCK: begin
        if (!left_mouse && !right_mouse) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign wr_chg = wr_en && (wr_val != val_q[wr_idx]);

  // NOTE: the value array is a handful of flops, not a RAM, so it is reset like any other state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      cnt_q         <= '0;
      lat_idx_q     <= '0;
      lat_up_q      <= 1'b0;
      prev_l        <= 1'b0;
      prev_r        <= 1'b0;
      change_strobe <= 1'b0;
      change_idx    <= '0;
      active_idx    <= '1;
      for (int i = 0; i < NUM_CTRL; i++) val_q[i] <= VAL_INIT;
    end else begin
      // NOTE: non-blocking assignments here so every register samples pre-edge values.
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      lat_idx_q     <= lat_idx_d;
      lat_up_q      <= lat_up_d;
      prev_l        <= left_mouse;
      prev_r        <= right_mouse;
      change_strobe <= wr_chg;
      active_idx    <= zone_valid ? {1'b0, zone} : '1;
      if (wr_en) val_q[wr_idx] <= wr_val;
      if (wr_chg) change_idx <= wr_idx;
    end
  end

  for (genvar i = 0; i < NUM_CTRL; i++) begin : g_pack
    assign values[i*VAL_W +: VAL_W] = val_q[i];
  end

endmodule
